// File: rtl/spi_slave_4mb.sv
// ----------------------------------------------------------------------------
// spi_slave_4mb
// SPI slave front end for the 4MB board register space. The SPI bus is
// oversampled on clk_100m and 56-bit frames (cmd[7:0], addr[15:0],
// data[31:0], MSB first, mode 0) are decoded into register writes and reads.
//
// Ports:
//   clk_100m       system clock
//   rst_n_syn      asynchronous active-low reset
//   spi_sclk       SPI clock from master (CPOL=0, CPHA=0)
//   spi_cs_n       chip select, active-low
//   spi_mosi       serial data from master
//   spi_miso       serial data to master
//   spi_miso_oe    MISO output enable (1 = drive)
//   addr           frame address, held until the next frame's address completes
//   data_mosi      write data, held until the next write completes
//   data_mosi_rdy  one-cycle strobe: addr/data_mosi hold a valid write
//   rd_req         one-cycle strobe: read requested at addr
//   rd_data        read value from the downstream register mux
//   frame_err      one-cycle strobe: aborted or malformed frame
// ----------------------------------------------------------------------------
module spi_slave_4mb #(
    parameter logic [7:0]  CMD_WRITE   = 8'h02,
    parameter logic [7:0]  CMD_READ    = 8'h03,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic        clk_100m,
    input  logic        rst_n_syn,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [15:0] addr,
    output logic [31:0] data_mosi,
    output logic        data_mosi_rdy,
    output logic        rd_req,
    input  logic [31:0] rd_data,
    output logic        frame_err
);

    localparam int unsigned LAST = SYNC_STAGES - 1;
    localparam int unsigned PREV = SYNC_STAGES - 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WR_DATA,
        RD_DATA,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] flush_pipe;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [30:0] shift_in;
    logic [31:0] shifted;
    logic [31:0] miso_shift;
    logic        is_read;
    logic        rd_load;
    logic        cs_armed;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_high;
    logic mosi_bit;
    logic sync_valid;

    // Synchronisers; index 0 is the newest sample.
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            flush_pipe <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            flush_pipe <= {flush_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        sclk_rise  = sclk_sync[PREV] & ~sclk_sync[LAST];
        sclk_fall  = ~sclk_sync[PREV] & sclk_sync[LAST];
        cs_fall    = ~cs_sync[PREV] & cs_sync[LAST];
        cs_high    = cs_sync[PREV];
        mosi_bit   = mosi_sync[LAST];
        sync_valid = flush_pipe[LAST];
        shifted    = {shift_in, mosi_bit};
    end

    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_in      <= '0;
            miso_shift    <= '0;
            is_read       <= 1'b0;
            rd_load       <= 1'b0;
            cs_armed      <= 1'b0;
            addr          <= '0;
            data_mosi     <= '0;
            data_mosi_rdy <= 1'b0;
            rd_req        <= 1'b0;
            frame_err     <= 1'b0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
        end else begin
            data_mosi_rdy <= 1'b0;
            rd_req        <= 1'b0;
            frame_err     <= 1'b0;
            rd_load       <= rd_req;

            // rd_data is valid the cycle after rd_req.
            if (rd_load) begin
                miso_shift <= rd_data;
            end

            // The cs_n chain resets to "high", so a reset taken while cs_n is
            // held low would look like a falling edge once the chain flushes.
            // Only arm frame start after a genuine high has been sampled.
            if (cs_high && sync_valid) begin
                cs_armed <= 1'b1;
            end

            if (state == IDLE) begin
                if (cs_fall && cs_armed) begin
                    state   <= CMD;
                    bit_cnt <= '0;
                end
            end else if (cs_high) begin
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                // A read counts as complete once all 56 rises are in; a
                // cs_n pulse with no sclk edges is a silent glitch.
                if (state == RD_DATA) begin
                    frame_err <= (bit_cnt != 6'd56);
                end else begin
                    frame_err <= (state != IGNORE) && (bit_cnt != '0);
                end
            end else begin
                case (state)
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shifted[30:0];
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) begin
                                is_read <= (shifted[7:0] == CMD_READ);
                                if ((shifted[7:0] == CMD_WRITE) ||
                                    (shifted[7:0] == CMD_READ)) begin
                                    state <= ADDR;
                                end else begin
                                    state     <= IGNORE;
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= shifted[30:0];
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd23) begin
                                addr <= shifted[15:0];
                                if (is_read) begin
                                    state       <= RD_DATA;
                                    rd_req      <= 1'b1;
                                    spi_miso_oe <= 1'b1;
                                end else begin
                                    state <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            shift_in <= shifted[30:0];
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd55) begin
                                data_mosi     <= shifted;
                                data_mosi_rdy <= 1'b1;
                                state         <= IGNORE;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                        // Falls 24..55 present bits 31..0; fall 56 ends the read.
                        if (sclk_fall) begin
                            if (bit_cnt == 6'd56) begin
                                spi_miso <= 1'b0;
                                state    <= IGNORE;
                            end else begin
                                spi_miso   <= miso_shift[31];
                                miso_shift <= {miso_shift[30:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_4mb.sv
module tb_spi_slave_4mb;

    logic        clk_100m;
    logic        rst_n_syn;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] addr;
    logic [31:0] data_mosi;
    logic        data_mosi_rdy;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        frame_err;

    logic [31:0] regfile [16];

    spi_slave_4mb #(
        .CMD_WRITE  (8'h02),
        .CMD_READ   (8'h03),
        .SYNC_STAGES(3)
    ) dut (
        .clk_100m     (clk_100m),
        .rst_n_syn    (rst_n_syn),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .addr         (addr),
        .data_mosi    (data_mosi),
        .data_mosi_rdy(data_mosi_rdy),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .frame_err    (frame_err)
    );

    // Downstream register mux driven from addr.
    assign rd_data = regfile[addr[3:0]];

    initial begin
        clk_100m = 1'b0;
        forever #5 clk_100m = ~clk_100m;
    end

    int total = 0;
    int bad   = 0;

    // Strobe monitor: monotonic counters, diffed per frame.
    int          mon_rdy  = 0;
    int          mon_rq   = 0;
    int          mon_err  = 0;
    int          mon_excl = 0;
    logic [31:0] mon_wr_data = '0;
    logic [15:0] mon_wr_addr = '0;
    logic [15:0] mon_rq_addr = '0;

    always @(negedge clk_100m) begin
        if (data_mosi_rdy) begin
            mon_rdy     <= mon_rdy + 1;
            mon_wr_data <= data_mosi;
            mon_wr_addr <= addr;
        end
        if (rd_req) begin
            mon_rq      <= mon_rq + 1;
            mon_rq_addr <= addr;
        end
        if (frame_err) mon_err <= mon_err + 1;
        if (32'(data_mosi_rdy) + 32'(rd_req) + 32'(frame_err) > 1)
            mon_excl <= mon_excl + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 64'(addr), 64'h0);
        chk({tag, "_data"}, 64'(data_mosi), 64'h0);
        chk({tag, "_strb"}, 64'({data_mosi_rdy, rd_req, frame_err}), 64'h0);
        chk({tag, "_miso"}, 64'({spi_miso, spi_miso_oe}), 64'h0);
    endtask

    // SPI master, mode 0, 10 MHz. All actions happen at t = 2 (mod 10),
    // away from clk_100m edges. Master samples MISO just before each rise.
    task automatic run_frame(input logic [63:0] stream, input int nbits, input bit rd,
                             input int rst_bit, input int gap,
                             output logic [31:0] miso_word, output int oe_bad);
        logic exp_oe;
        miso_word = '0;
        oe_bad    = 0;
        spi_cs_n  = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = stream[63 - i];
            #50;
            if (i == rst_bit) begin
                rst_n_syn = 1'b0;
                #1;
                chk_reset_vals("rst_mid");
                #9;
                rst_n_syn = 1'b1;
            end
            if (i >= 24 && i < 56) miso_word = {miso_word[30:0], spi_miso};
            exp_oe = rd && (i >= 24) && (i < 56);
            if (!(rd && i >= 56) && (spi_miso_oe !== exp_oe)) oe_bad++;
            spi_sclk = 1'b1;
            #50;
            spi_sclk = 1'b0;
        end
        #50;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(gap);
    endtask

    task automatic apply(input string tag, input logic [7:0] cmd, input logic [15:0] a,
                         input logic [31:0] d, input int nbits, input int gap,
                         input int e_rdy, input int e_err, input int e_rq,
                         input logic [15:0] e_addr, input logic [31:0] e_data,
                         input logic [31:0] e_miso, input bit chk_miso);
        int          r0, q0, e0, x0, oe_bad;
        logic [31:0] mw;
        logic [7:0]  extra;
        r0 = mon_rdy; q0 = mon_rq; e0 = mon_err; x0 = mon_excl;
        extra = 8'($urandom);
        run_frame({cmd, a, d, extra}, nbits, (cmd == 8'h03), -1, gap, mw, oe_bad);
        chk({tag, "_rdy"},  64'(mon_rdy - r0), 64'(e_rdy));
        chk({tag, "_err"},  64'(mon_err - e0), 64'(e_err));
        chk({tag, "_rq"},   64'(mon_rq - q0),  64'(e_rq));
        chk({tag, "_excl"}, 64'(mon_excl - x0), 64'h0);
        chk({tag, "_addr"}, 64'(addr), 64'(e_addr));
        chk({tag, "_data"}, 64'(data_mosi), 64'(e_data));
        chk({tag, "_oe"},   64'(oe_bad), 64'h0);
        chk({tag, "_oe_idle"}, 64'({spi_miso_oe, spi_miso}), 64'h0);
        if (e_rdy != 0) chk({tag, "_wr_addr"}, 64'(mon_wr_addr), 64'(e_addr));
        if (e_rq != 0)  chk({tag, "_rq_addr"}, 64'(mon_rq_addr), 64'(e_addr));
        if (chk_miso)   chk({tag, "_miso"}, 64'(mw), 64'(e_miso));
    endtask

    // Reference model: frame outcome from the frame rules alone.
    logic [15:0] m_addr;
    logic [31:0] m_data;

    task automatic model(input logic [7:0] cmd, input logic [15:0] a, input logic [31:0] d,
                         input int nbits, output int e_rdy, output int e_err,
                         output int e_rq, output bit full_read);
        bit valid;
        e_rdy = 0; e_err = 0; e_rq = 0; full_read = 0;
        valid = (cmd == 8'h02) || (cmd == 8'h03);
        if (nbits == 0) begin
        end else if (nbits < 8 || !valid) begin
            e_err = 1;
        end else begin
            if (nbits >= 24) begin
                m_addr = a;
                e_rq   = (cmd == 8'h03) ? 1 : 0;
            end
            if (nbits < 56) e_err = 1;
            else if (cmd == 8'h02) begin
                e_rdy  = 1;
                m_data = d;
            end else full_read = 1;
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [31:0] d;
        int          nbits;
        int          gap;
        int          e_rdy;
        int          e_err;
        int          e_rq;
        logic [15:0] e_addr;
        logic [31:0] e_data;
        logic [31:0] e_miso;
        bit          chk_miso;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          oe_bad, r0, q0, e0, e_rdy, e_err, e_rq;
        bit          full_read;
        logic [31:0] mw;

        for (int i = 0; i < 16; i++) regfile[i] = $urandom;
        regfile[4] = 32'h0001_0203;

        vecs[0] = '{8'h02, 16'h0010, 32'hA5A55A5A, 56, 1000, 1, 0, 0, 16'h0010, 32'hA5A55A5A, 32'h0, 1'b0};
        vecs[1] = '{8'h03, 16'h0004, 32'h0,        56, 1000, 0, 0, 1, 16'h0004, 32'hA5A55A5A, 32'h00010203, 1'b1};
        vecs[2] = '{8'h02, 16'h0020, 32'hDEADBEEF, 40, 1000, 0, 1, 0, 16'h0020, 32'hA5A55A5A, 32'h0, 1'b0};
        vecs[3] = '{8'h7F, 16'h1234, 32'h5678ABCD, 56, 1000, 0, 1, 0, 16'h0020, 32'hA5A55A5A, 32'h0, 1'b0};
        vecs[4] = '{8'h02, 16'h0010, 32'h11111111, 56, 1000, 1, 0, 0, 16'h0010, 32'h11111111, 32'h0, 1'b0};
        vecs[5] = '{8'h02, 16'h0014, 32'h22222222, 56, 1000, 1, 0, 0, 16'h0014, 32'h22222222, 32'h0, 1'b0};
        vecs[6] = '{8'h02, 16'h0018, 32'h33333333, 64, 1000, 1, 0, 0, 16'h0018, 32'h33333333, 32'h0, 1'b0};
        vecs[7] = '{8'h02, 16'hFFFF, 32'hFFFFFFFF, 0,  1000, 0, 0, 0, 16'h0018, 32'h33333333, 32'h0, 1'b0};

        rst_n_syn = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        #22;
        chk_reset_vals("reset");
        rst_n_syn = 1'b1;
        #200;

        for (int i = 0; i < 8; i++) begin
            apply($sformatf("v%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].d, vecs[i].nbits,
                  vecs[i].gap, vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_rq, vecs[i].e_addr,
                  vecs[i].e_data, vecs[i].e_miso, vecs[i].chk_miso);
        end

        // Reset asserted at bit 30 of a write; rest of the frame is dropped.
        r0 = mon_rdy; q0 = mon_rq; e0 = mon_err;
        run_frame({8'h02, 16'h0044, 32'hCAFEF00D, 8'h00}, 56, 1'b0, 30, 1000, mw, oe_bad);
        chk("rst_frame_strb", 64'((mon_rdy - r0) + (mon_rq - q0) + (mon_err - e0)), 64'h0);
        chk_reset_vals("rst_after");
        m_addr = '0;
        m_data = '0;
        apply("rst_next", 8'h02, 16'h0048, 32'h600DF00D, 56, 1000, 1, 0, 0,
              16'h0048, 32'h600DF00D, 32'h0, 1'b0);
        m_addr = 16'h0048;
        m_data = 32'h600DF00D;

        // Randomized frames against the model.
        for (int i = 0; i < 30; i++) begin
            logic [7:0]  cmd;
            logic [15:0] a;
            logic [31:0] d;
            int          nb, c, r;
            c = int'($urandom_range(0, 9));
            cmd = (c < 4) ? 8'h02 : (c < 8) ? 8'h03 : 8'($urandom);
            a = 16'($urandom);
            d = $urandom;
            r = int'($urandom_range(0, 9));
            nb = (r < 7) ? 56 : (r == 7) ? 64 : int'($urandom_range(0, 55));
            model(cmd, a, d, nb, e_rdy, e_err, e_rq, full_read);
            apply($sformatf("rnd%0d", i), cmd, a, d, nb, 200, e_rdy, e_err, e_rq,
                  m_addr, m_data, regfile[a[3:0]], full_read);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
